// File: rtl/popcount_pkg.sv
// Shared types and helpers for the sequential population counter.
package popcount_pkg;

  // Control states of the counter: waiting for a word, counting chunks, holding a result.
  typedef enum logic [1:0] {
    PC_IDLE = 2'd0,
    PC_BUSY = 2'd1,
    PC_DONE = 2'd2
  } pc_state_e;

  // Bits needed to hold a count from 0 up to and including w.
  function automatic int pc_cw(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/popcount_chunk.sv
// Combinational ones counter for one CHUNK-bit slice; the general form of a
// chain of one-bit count cells.
module popcount_chunk
  import popcount_pkg::*;
#(
  parameter int  CHUNK = 1,
  localparam int OW    = pc_cw(CHUNK)
) (
  input  logic [CHUNK-1:0] chunk_bits,
  output logic [OW-1:0]    chunk_count
);

  // Add up the set bits of the slice, one cell per bit.
  always_comb begin
    chunk_count = {OW{1'b0}};
    for (int i = 0; i < CHUNK; i++) begin
      chunk_count = chunk_count + OW'(chunk_bits[i]);
    end
  end

endmodule

// File: rtl/popcount_seq.sv
// Sequential ones/zeros counter with valid/ready handshakes on both sides.
// A word is inverted on capture when zeros are requested, so the datapath only
// ever counts ones. The word register shifts right by CHUNK each busy cycle, so
// the slice being counted is always its low CHUNK bits.
module popcount_seq
  import popcount_pkg::*;
#(
  parameter int  WIDTH = 8,
  parameter int  CHUNK = 1,
  localparam int CW    = pc_cw(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    out_count,
  output logic             out_mode
);

  localparam int CHUNK_SAFE = (CHUNK < 1) ? 1 : CHUNK;
  localparam int NCH        = WIDTH / CHUNK_SAFE;
  localparam int IW         = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int OW         = pc_cw(CHUNK_SAFE);

  if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK_SAFE) != 0)) begin : g_param_check
    $error("popcount_seq: CHUNK must be in 1..WIDTH and divide WIDTH");
  end

  pc_state_e        state_r;
  pc_state_e        next_state_s;
  logic [WIDTH-1:0] word_r;
  logic             mode_r;
  logic [CW-1:0]    acc_r;
  logic [IW-1:0]    idx_r;
  logic [OW-1:0]    chunk_count_s;
  logic [CW-1:0]    chunk_sum_s;
  logic             last_chunk_s;
  logic             accept_s;
  logic             finish_s;
  logic             drain_s;

  popcount_chunk #(
    .CHUNK (CHUNK_SAFE)
  ) u_chunk (
    .chunk_bits  (word_r[CHUNK_SAFE-1:0]),
    .chunk_count (chunk_count_s)
  );

  // Running total including the slice currently presented to the chunk counter.
  always_comb begin
    chunk_sum_s  = acc_r + CW'(chunk_count_s);
    last_chunk_s = (idx_r == IW'(NCH - 1));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= PC_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next state, input-side ready and the per-cycle datapath strobes.
  always_comb begin
    next_state_s = state_r;
    in_ready     = 1'b0;
    accept_s     = 1'b0;
    finish_s     = 1'b0;
    drain_s      = 1'b0;
    case (state_r)
      PC_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept_s     = 1'b1;
          next_state_s = PC_BUSY;
        end else begin
          next_state_s = PC_IDLE;
        end
      end
      PC_BUSY: begin
        if (last_chunk_s) begin
          finish_s     = 1'b1;
          next_state_s = PC_DONE;
        end else begin
          next_state_s = PC_BUSY;
        end
      end
      PC_DONE: begin
        // A new word may enter on the same edge the held result leaves.
        in_ready = out_ready;
        if (out_ready) begin
          drain_s = 1'b1;
          if (in_valid) begin
            accept_s     = 1'b1;
            next_state_s = PC_BUSY;
          end else begin
            next_state_s = PC_IDLE;
          end
        end else begin
          next_state_s = PC_DONE;
        end
      end
      default: begin
        next_state_s = PC_IDLE;
      end
    endcase
  end

  // Word capture, chunk-by-chunk accumulation and the registered result.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_r    <= {WIDTH{1'b0}};
      mode_r    <= 1'b0;
      acc_r     <= {CW{1'b0}};
      idx_r     <= {IW{1'b0}};
      out_valid <= 1'b0;
      out_count <= {CW{1'b0}};
      out_mode  <= 1'b0;
    end else begin
      if (accept_s) begin
        word_r <= in_mode ? ~in_data : in_data;
        mode_r <= in_mode;
        acc_r  <= {CW{1'b0}};
        idx_r  <= {IW{1'b0}};
      end else if (state_r == PC_BUSY) begin
        word_r <= word_r >> CHUNK_SAFE;
        acc_r  <= chunk_sum_s;
        idx_r  <= idx_r + IW'(1);
      end else begin
        word_r <= word_r;
        acc_r  <= acc_r;
        idx_r  <= idx_r;
      end

      if (finish_s) begin
        out_valid <= 1'b1;
        out_count <= chunk_sum_s;
        out_mode  <= mode_r;
      end else if (drain_s) begin
        out_valid <= 1'b0;
      end else begin
        out_valid <= out_valid;
      end
    end
  end

endmodule

// File: tb/tb_popcount_seq.sv
// Scoreboard bench for popcount_seq: three instances (8/1, 32/4, 8/8), directed
// cases followed by randomized traffic with output backpressure.
module tb_popcount_seq;

  localparam int NI = 3;

  typedef struct {
    int count;
    bit mode;
    int acc_cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [NI-1:0] in_valid;
  logic [NI-1:0] in_ready;
  logic [NI-1:0] in_mode;
  logic [NI-1:0] out_valid;
  logic [NI-1:0] out_ready;
  logic [NI-1:0] out_mode;
  logic [31:0]   in_data [NI];
  logic [3:0]    cnt0;
  logic [5:0]    cnt1;
  logic [3:0]    cnt2;

  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;
  bit   rnd_done = 1'b0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  bit   prev_valid [NI];
  bit   prev_xfer  [NI];

  popcount_seq #(.WIDTH(8), .CHUNK(1)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0][7:0]), .in_mode(in_mode[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_count(cnt0), .out_mode(out_mode[0]));

  popcount_seq #(.WIDTH(32), .CHUNK(4)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .in_mode(in_mode[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_count(cnt1), .out_mode(out_mode[1]));

  popcount_seq #(.WIDTH(8), .CHUNK(8)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_data(in_data[2][7:0]), .in_mode(in_mode[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .out_count(cnt2), .out_mode(out_mode[2]));

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int width_of(int i);
    case (i)
      0:       return 8;
      1:       return 32;
      default: return 8;
    endcase
  endfunction

  function automatic int chunk_of(int i);
    case (i)
      0:       return 1;
      1:       return 4;
      default: return 8;
    endcase
  endfunction

  function automatic int dut_count(int i);
    case (i)
      0:       return int'(cnt0);
      1:       return int'(cnt1);
      default: return int'(cnt2);
    endcase
  endfunction

  // Reference: number of ones in the word, or of zeros when mode is set.
  function automatic int ref_count(int w, logic [31:0] d, bit m);
    logic [31:0] mask;
    int          ones;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    ones = $countones(d & mask);
    return m ? (w - ones) : ones;
  endfunction

  function automatic int q_size(int i);
    case (i)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic exp_t q_front(int i);
    case (i)
      0:       return q0[0];
      1:       return q1[0];
      default: return q2[0];
    endcase
  endfunction

  task automatic push_exp(int i, exp_t e);
    case (i)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic pop_exp(int i);
    case (i)
      0:       void'(q0.pop_front());
      1:       void'(q1.pop_front());
      default: void'(q2.pop_front());
    endcase
  endtask

  task automatic check(string name, int inst, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s (inst %0d, cycle %0d): got %0d, expected %0d", name, inst, cyc, act, exp);
    end
  endtask

  // Offer one word; record the expectation when the DUT will take it on the next edge.
  task automatic send(int i, logic [31:0] d, bit m, output int waits);
    exp_t e;
    @(negedge clk);
    in_valid[i] = 1'b1;
    in_data[i]  = d;
    in_mode[i]  = m;
    #1;
    waits = 0;
    while (!in_ready[i] && waits < 200) begin
      @(negedge clk);
      #1;
      waits++;
    end
    if (!in_ready[i]) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout (inst %0d): in_ready never rose", i);
      in_valid[i] = 1'b0;
    end else begin
      e.count   = ref_count(width_of(i), d, m);
      e.mode    = m;
      e.acc_cyc = cyc + 1;
      push_exp(i, e);
      @(posedge clk);
      #1;
      in_valid[i] = 1'b0;
    end
  endtask

  // Present a junk word for one cycle while the block is busy; it must be refused.
  task automatic poke(int i);
    @(negedge clk);
    in_valid[i] = 1'b1;
    in_data[i]  = $urandom;
    in_mode[i]  = 1'($urandom_range(0, 1));
    #1;
    check("busy_in_ready", i, int'(in_ready[i]), 0);
    @(posedge clk);
    #1;
    in_valid[i] = 1'b0;
  endtask

  task automatic drain_wait(int i);
    int n;
    n = 0;
    while (q_size(i) != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (q_size(i) != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout (inst %0d): %0d results outstanding", i, q_size(i));
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every presented result with the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      for (int i = 0; i < NI; i++) begin
        prev_valid[i] = 1'b0;
        prev_xfer[i]  = 1'b0;
      end
    end else begin
      for (int i = 0; i < NI; i++) begin
        if (prev_valid[i] && !prev_xfer[i]) begin
          check("valid_held", i, int'(out_valid[i]), 1);
        end
        if (out_valid[i]) begin
          if (q_size(i) == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_output (inst %0d, cycle %0d): count %0d with nothing outstanding",
                     i, cyc, dut_count(i));
          end else begin
            e = q_front(i);
            if (!prev_valid[i] || prev_xfer[i]) begin
              check("latency", i, cyc - e.acc_cyc, width_of(i) / chunk_of(i));
            end
            check("count", i, dut_count(i), e.count);
            check("mode", i, int'(out_mode[i]), int'(e.mode));
            if (out_ready[i]) begin
              pop_exp(i);
            end
          end
        end
        prev_xfer[i]  = out_valid[i] && out_ready[i];
        prev_valid[i] = out_valid[i];
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int n;
    int c_prev;
    rst       = 1'b1;
    in_valid  = '0;
    in_mode   = '0;
    out_ready = '1;
    for (int i = 0; i < NI; i++) in_data[i] = 32'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state.
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check("rst_out_valid", i, int'(out_valid[i]), 0);
      check("rst_in_ready", i, int'(in_ready[i]), 1);
      check("rst_out_count", i, dut_count(i), 0);
      check("rst_out_mode", i, int'(out_mode[i]), 0);
    end

    // 8-bit, one bit per cycle: extremes and mixed patterns in both modes.
    send(0, 32'hFF, 1'b0, w);
    send(0, 32'h00, 1'b1, w);
    send(0, 32'hA5, 1'b0, w);
    send(0, 32'hA5, 1'b1, w);
    send(0, 32'h01, 1'b1, w);
    send(0, 32'h00, 1'b0, w);
    drain_wait(0);

    // Backpressure in DONE, then drain and accept on the same edge.
    out_ready[0] = 1'b0;
    send(0, 32'h07, 1'b0, w);
    n = 0;
    while (!out_valid[0] && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("bp_result_arrived", 0, int'(out_valid[0]), 1);
    repeat (5) begin
      @(negedge clk);
      check("bp_in_ready", 0, int'(in_ready[0]), 0);
    end
    @(posedge clk);
    #1 out_ready[0] = 1'b1;
    send(0, 32'h0F, 1'b0, w);
    check("same_edge_accept", 0, w, 0);
    drain_wait(0);

    // Reset in the middle of a count: nothing may come out afterwards.
    send(0, 32'hFF, 1'b0, w);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    q0.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", 0, int'(out_valid[0]), 0);
    check("midrst_in_ready", 0, int'(in_ready[0]), 1);
    repeat (12) @(negedge clk);
    check("midrst_no_stale", 0, int'(out_valid[0]), 0);

    // 32-bit, four bits per cycle.
    send(1, 32'hF0F0_0001, 1'b0, w);
    send(1, 32'hFFFF_FFFF, 1'b1, w);
    drain_wait(1);

    // 8-bit single-cycle compute and back-to-back throughput.
    send(2, 32'h3C, 1'b0, w);
    c_prev = cyc;
    for (int k = 0; k < 4; k++) begin
      send(2, $urandom, 1'($urandom_range(0, 1)), w);
      check("throughput_spacing", 2, cyc - c_prev, 2);
      c_prev = cyc;
    end
    drain_wait(2);

    // Randomized traffic on all instances, with random backpressure on the wide one.
    fork
      begin
        fork
          begin
            int w0;
            for (int k = 0; k < 30; k++) begin
              send(0, $urandom, 1'($urandom_range(0, 1)), w0);
              if ($urandom_range(0, 1) == 1) poke(0);
              repeat ($urandom_range(0, 3)) @(posedge clk);
            end
          end
          begin
            int w1;
            for (int k = 0; k < 30; k++) begin
              send(1, $urandom, 1'($urandom_range(0, 1)), w1);
              repeat ($urandom_range(0, 3)) @(posedge clk);
            end
          end
          begin
            int w2;
            for (int k = 0; k < 30; k++) begin
              send(2, $urandom, 1'($urandom_range(0, 1)), w2);
              if ($urandom_range(0, 1) == 1) poke(2);
              repeat ($urandom_range(0, 2)) @(posedge clk);
            end
          end
        join
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1 out_ready[1] = 1'($urandom_range(0, 1));
        end
        out_ready[1] = 1'b1;
      end
    join
    for (int i = 0; i < NI; i++) drain_wait(i);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
